// File: rtl/gshare_predictor_pkg.sv
// Shared branch-predictor defaults; instantiators and ROB entry widths derive from these.
// Also holds the counter reset value helper used by the counter table.
package gshare_predictor_pkg;

  localparam int BP_IDX_BITS  = 7;
  localparam int BP_CNT_BITS  = 2;
  localparam int BP_HIST_BITS = 7;

  // Weakly not-taken: one below the taken threshold (MSB set).
  function automatic int unsigned bp_weak_nt(input int unsigned cnt_bits);
    return (32'd1 << (cnt_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Saturating counter array: combinational read, write lands at the next clk edge (no bypass).
// Always accepts a write when wr_en is high; no backpressure.
module bp_counter_table
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int CNT_BITS = BP_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [CNT_BITS-1:0] rd_cnt,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(bp_weak_nt(CNT_BITS));

  logic [CNT_BITS-1:0] cnt_q [ENTRIES];
  logic [CNT_BITS-1:0] wr_cur;
  logic [CNT_BITS-1:0] wr_nxt;

  assign rd_cnt = cnt_q[rd_idx];
  assign wr_cur = cnt_q[wr_idx];

  always_comb begin
    wr_nxt = wr_cur;
    if (wr_taken) begin
      if (wr_cur != '1) wr_nxt = wr_cur + 1'b1;
    end else begin
      if (wr_cur != '0) wr_nxt = wr_cur - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= wr_nxt;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: zero-latency combinational predict, trained/repaired at ROB commit.
// No backpressure; rdy low freezes all state. Optional commit/mispredict counters under BP_STATS_EN.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_BITS  = BP_IDX_BITS,
  parameter int CNT_BITS  = BP_CNT_BITS,
  parameter int HIST_BITS = BP_HIST_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                if_query,
  input  logic [31:0]         if_pc,
  output logic                predict,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                rob_commit,
  input  logic [IDX_BITS-1:0] commit_idx,
  input  logic                commit_taken,
  input  logic                commit_mispred,
  output logic [31:0]         stat_commits,
  output logic [31:0]         stat_mispreds
);

  logic                commit_en;
  logic [IDX_BITS-1:0] hist_idx;
  logic [CNT_BITS-1:0] rd_cnt;
  logic                unused_ok;

  assign commit_en = rdy & rob_commit;
  assign pred_idx  = if_pc[IDX_BITS+1:2] ^ hist_idx;
  assign predict   = rd_cnt[CNT_BITS-1];
  assign unused_ok = ^{if_pc[31:IDX_BITS+2], if_pc[1:0], if_query, commit_mispred};

  generate
    if (HIST_BITS > 0) begin : g_hist
      logic [HIST_BITS-1:0] ghr_spec;
      logic [HIST_BITS-1:0] ghr_arch;
      logic [HIST_BITS-1:0] ghr_arch_nxt;

      assign ghr_arch_nxt = (ghr_arch << 1) | HIST_BITS'(commit_taken);
      assign hist_idx     = IDX_BITS'(ghr_spec);

      // A mispredict flushes IF, so the repair overrides any same-cycle speculative shift.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ghr_spec <= '0;
          ghr_arch <= '0;
        end else if (rdy) begin
          if (rob_commit) ghr_arch <= ghr_arch_nxt;
          if (rob_commit && commit_mispred) ghr_spec <= ghr_arch_nxt;
          else if (if_query) ghr_spec <= (ghr_spec << 1) | HIST_BITS'(predict);
        end
      end
    end else begin : g_bimodal
      assign hist_idx = '0;
    end
  endgenerate

  bp_counter_table #(
    .IDX_BITS (IDX_BITS),
    .CNT_BITS (CNT_BITS)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pred_idx),
    .rd_cnt   (rd_cnt),
    .wr_en    (commit_en),
    .wr_idx   (commit_idx),
    .wr_taken (commit_taken)
  );

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_commits  <= '0;
      stat_mispreds <= '0;
    end else if (commit_en) begin
      stat_commits <= stat_commits + 32'd1;
      if (commit_mispred) stat_mispreds <= stat_mispreds + 32'd1;
    end
  end
`else
  assign stat_commits  = '0;
  assign stat_mispreds = '0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_query = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        rob_commit = 1'b0;
  logic [6:0]  commit_idx = 7'h0;
  logic        commit_taken = 1'b0;
  logic        commit_mispred = 1'b0;

  logic        predict, predict_b;
  logic [6:0]  pred_idx, pred_idx_b;
  logic [31:0] stat_commits, stat_mispreds, stat_commits_b, stat_mispreds_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_commits, exp_mispreds;

  always #5 clk = ~clk;

  gshare_predictor #(.IDX_BITS(7), .CNT_BITS(2), .HIST_BITS(7)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_query(if_query), .if_pc(if_pc),
    .predict(predict), .pred_idx(pred_idx), .rob_commit(rob_commit),
    .commit_idx(commit_idx), .commit_taken(commit_taken), .commit_mispred(commit_mispred),
    .stat_commits(stat_commits), .stat_mispreds(stat_mispreds)
  );

  gshare_predictor #(.IDX_BITS(7), .CNT_BITS(2), .HIST_BITS(0)) dut_bim (
    .clk(clk), .rst(rst), .rdy(rdy), .if_query(if_query), .if_pc(if_pc),
    .predict(predict_b), .pred_idx(pred_idx_b), .rob_commit(rob_commit),
    .commit_idx(commit_idx), .commit_taken(commit_taken), .commit_mispred(commit_mispred),
    .stat_commits(stat_commits_b), .stat_mispreds(stat_mispreds_b)
  );

  task automatic do_commit(input logic [6:0] idx, input logic tk, input logic mp);
    rob_commit = 1'b1; commit_idx = idx; commit_taken = tk; commit_mispred = mp;
    @(posedge clk); #1;
    rob_commit = 1'b0; commit_taken = 1'b0; commit_mispred = 1'b0;
  endtask

  task automatic do_query();
    if_query = 1'b1;
    @(posedge clk); #1;
    if_query = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    if_pc = 32'h14;
    #1;
    checks++; if (predict_b !== 1'b0) begin errors++; $display("FAIL rst_init_predict: got %0d expected 0", predict_b); end
    checks++; if (pred_idx !== 7'h05) begin errors++; $display("FAIL rst_init_idx: got %0h expected 05", pred_idx); end
    do_commit(7'h05, 1'b1, 1'b1);
    checks++; if (predict_b !== 1'b1) begin errors++; $display("FAIL rst_trained_predict: got %0d expected 1", predict_b); end
    checks++; if (pred_idx !== 7'h04) begin errors++; $display("FAIL rst_spec_idx: got %0h expected 04", pred_idx); end
    #2; rst = 1'b1; #1;
    checks++; if (predict_b !== 1'b0) begin errors++; $display("FAIL rst_async_predict: got %0d expected 0", predict_b); end
    checks++; if (pred_idx !== 7'h05) begin errors++; $display("FAIL rst_async_idx: got %0h expected 05", pred_idx); end
    checks++; if (stat_commits !== 32'd0) begin errors++; $display("FAIL rst_stat_commits: got %0d expected 0", stat_commits); end
    checks++; if (stat_mispreds !== 32'd0) begin errors++; $display("FAIL rst_stat_mispreds: got %0d expected 0", stat_mispreds); end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    if_pc = 32'h14;
    for (int i = 0; i < 4; i++) begin
      do_commit(7'h05, 1'b1, 1'b0);
      checks++; if (predict_b !== 1'b1) begin errors++; $display("FAIL sat_taken_%0d: got %0d expected 1", i, predict_b); end
    end
    do_commit(7'h05, 1'b0, 1'b0);
    checks++; if (predict_b !== 1'b1) begin errors++; $display("FAIL sat_nt1: got %0d expected 1", predict_b); end
    rob_commit = 1'b1; commit_idx = 7'h05; commit_taken = 1'b0;
    #1;
    checks++; if (predict_b !== 1'b1) begin errors++; $display("FAIL sat_no_bypass: got %0d expected 1", predict_b); end
    @(posedge clk); #1;
    rob_commit = 1'b0;
    checks++; if (predict_b !== 1'b0) begin errors++; $display("FAIL sat_nt2: got %0d expected 0", predict_b); end
    do_commit(7'h05, 1'b0, 1'b0);
    do_commit(7'h05, 1'b0, 1'b0);
    do_commit(7'h05, 1'b1, 1'b0);
    checks++; if (predict_b !== 1'b0) begin errors++; $display("FAIL sat_floor_t1: got %0d expected 0", predict_b); end
    do_commit(7'h05, 1'b1, 1'b0);
    checks++; if (predict_b !== 1'b1) begin errors++; $display("FAIL sat_floor_t2: got %0d expected 1", predict_b); end
  endtask

  task automatic test_history();
    do_reset();
    do_commit(7'h10, 1'b1, 1'b0);
    do_commit(7'h11, 1'b1, 1'b0);
    if_pc = 32'h40;
    #1;
    checks++; if (pred_idx !== 7'h10) begin errors++; $display("FAIL hist_idx0: got %0h expected 10", pred_idx); end
    checks++; if (predict !== 1'b1) begin errors++; $display("FAIL hist_pred0: got %0d expected 1", predict); end
    do_query();
    checks++; if (pred_idx !== 7'h11) begin errors++; $display("FAIL hist_idx1: got %0h expected 11", pred_idx); end
    checks++; if (predict !== 1'b1) begin errors++; $display("FAIL hist_pred1: got %0d expected 1", predict); end
    do_query();
    checks++; if (pred_idx !== 7'h13) begin errors++; $display("FAIL hist_idx2: got %0h expected 13", pred_idx); end
    checks++; if (predict !== 1'b0) begin errors++; $display("FAIL hist_pred2: got %0d expected 0", predict); end
    checks++; if (pred_idx_b !== 7'h10) begin errors++; $display("FAIL hist_bimodal_idx: got %0h expected 10", pred_idx_b); end
  endtask

  task automatic test_repair();
    do_reset();
    do_commit(7'h7f, 1'b1, 1'b1);
    do_commit(7'h7f, 1'b0, 1'b0);
    do_commit(7'h7f, 1'b1, 1'b0);
    if_pc = 32'h0;
    #1;
    checks++; if (pred_idx !== 7'h01) begin errors++; $display("FAIL rep_spec1: got %0h expected 01", pred_idx); end
    do_query();
    checks++; if (pred_idx !== 7'h02) begin errors++; $display("FAIL rep_spec2: got %0h expected 02", pred_idx); end
    rob_commit = 1'b1; commit_idx = 7'h7f; commit_taken = 1'b0; commit_mispred = 1'b1;
    if_query = 1'b1;
    @(posedge clk); #1;
    rob_commit = 1'b0; commit_mispred = 1'b0; if_query = 1'b0;
    checks++; if (pred_idx !== 7'h0a) begin errors++; $display("FAIL rep_wins: got %0h expected 0a", pred_idx); end
    do_commit(7'h7f, 1'b1, 1'b1);
    checks++; if (pred_idx !== 7'h15) begin errors++; $display("FAIL rep_arch: got %0h expected 15", pred_idx); end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    do_commit(7'h05, 1'b1, 1'b0);
    if_pc = 32'h14;
    rdy = 1'b0;
    rob_commit = 1'b1; commit_idx = 7'h05; commit_taken = 1'b0; commit_mispred = 1'b1;
    if_query = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (predict_b !== 1'b1) begin errors++; $display("FAIL rdy_cnt_b: got %0d expected 1", predict_b); end
    checks++; if (predict !== 1'b1) begin errors++; $display("FAIL rdy_cnt: got %0d expected 1", predict); end
    checks++; if (pred_idx !== 7'h05) begin errors++; $display("FAIL rdy_spec: got %0h expected 05", pred_idx); end
`ifdef BP_STATS_EN
    exp_commits = 32'd1;
`else
    exp_commits = 32'd0;
`endif
    checks++; if (stat_commits !== exp_commits) begin errors++; $display("FAIL rdy_stat: got %0d expected %0d", stat_commits, exp_commits); end
    checks++; if (stat_mispreds !== 32'd0) begin errors++; $display("FAIL rdy_stat_mis: got %0d expected 0", stat_mispreds); end
    if_pc = 32'h18;
    #1;
    checks++; if (pred_idx_b !== 7'h06) begin errors++; $display("FAIL rdy_track: got %0h expected 06", pred_idx_b); end
    rob_commit = 1'b0; commit_mispred = 1'b0; if_query = 1'b0;
    rdy = 1'b1;
    do_commit(7'h7f, 1'b1, 1'b1);
    if_pc = 32'h0;
    #1;
    checks++; if (pred_idx !== 7'h03) begin errors++; $display("FAIL rdy_arch: got %0h expected 03", pred_idx); end
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_commit(7'h7f, 1'(i), (i == 2 || i == 5 || i == 8) ? 1'b1 : 1'b0);
    end
`ifdef BP_STATS_EN
    exp_commits = 32'd10; exp_mispreds = 32'd3;
`else
    exp_commits = 32'd0;  exp_mispreds = 32'd0;
`endif
    checks++; if (stat_commits !== exp_commits) begin errors++; $display("FAIL stat_commits: got %0d expected %0d", stat_commits, exp_commits); end
    checks++; if (stat_mispreds !== exp_mispreds) begin errors++; $display("FAIL stat_mispreds: got %0d expected %0d", stat_mispreds, exp_mispreds); end
    checks++; if (stat_commits_b !== exp_commits) begin errors++; $display("FAIL stat_commits_b: got %0d expected %0d", stat_commits_b, exp_commits); end
    checks++; if (stat_mispreds_b !== exp_mispreds) begin errors++; $display("FAIL stat_mispreds_b: got %0d expected %0d", stat_mispreds_b, exp_mispreds); end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_history();
    test_repair();
    test_rdy_freeze();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
